// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes on both sides and registered
// result/flags. Single-cycle ops, shifts (one bit per cycle) and a shift-add
// multiplier (one partial product per cycle).
module alu_multicycle #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       Z
);

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_LSL = 3'b100,
    OP_LSR = 3'b101,
    OP_ASR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t             state_q;
  op_t                op_q;
  logic [2*WIDTH-1:0] data_q;   // operand A / shift register / multiplicand
  logic [WIDTH-1:0]   b_q;      // operand B / shift amount / multiplier
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   out_q;
  logic [2:0]         z_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [2*WIDTH-1:0] data_d;
  logic [WIDTH-1:0]   b_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   res_d;
  logic               v_d;
  logic [2:0]         flags_d;
  logic [WIDTH-1:0]   a_w;
  logic               shamt_nz;
  logic [2*WIDTH-1:0] mul_add;
  logic               is_shift;
  logic [CNT_W-1:0]   cnt_load;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign Z         = z_q;

  // Iteration count chosen at accept time from the incoming operation.
  always_comb begin
    is_shift = ALUop[2] & ~(&ALUop);
    cnt_load = CNT_W'(1);
    if (op_t'(ALUop) == OP_MUL) begin
      cnt_load = CNT_W'(WIDTH);
    end else if (is_shift && (Bin[SHAMT_W-1:0] != '0)) begin
      cnt_load = {1'b0, Bin[SHAMT_W-1:0]};
    end
  end

  // One datapath step on the latched state, plus the result/flags it yields.
  always_comb begin
    data_d   = data_q;
    b_d      = b_q;
    acc_d    = acc_q;
    res_d    = '0;
    v_d      = 1'b0;
    a_w      = data_q[WIDTH-1:0];
    shamt_nz = |b_q[SHAMT_W-1:0];
    mul_add  = b_q[0] ? data_q : '0;
    case (op_q)
      OP_ADD: begin
        res_d = a_w + b_q;
        v_d   = (a_w[WIDTH-1] & b_q[WIDTH-1] & ~res_d[WIDTH-1]) |
                (~a_w[WIDTH-1] & ~b_q[WIDTH-1] & res_d[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = a_w - b_q;
        v_d   = (a_w[WIDTH-1] & ~b_q[WIDTH-1] & ~res_d[WIDTH-1]) |
                (~a_w[WIDTH-1] & b_q[WIDTH-1] & res_d[WIDTH-1]);
      end
      OP_AND: res_d = a_w & b_q;
      OP_NOT: res_d = ~b_q;
      OP_LSL: begin
        res_d = shamt_nz ? (a_w << 1) : a_w;
        data_d = {data_q[2*WIDTH-1:WIDTH], res_d};
      end
      OP_LSR: begin
        res_d = shamt_nz ? (a_w >> 1) : a_w;
        data_d = {data_q[2*WIDTH-1:WIDTH], res_d};
      end
      OP_ASR: begin
        res_d = shamt_nz ? {a_w[WIDTH-1], a_w[WIDTH-1:1]} : a_w;
        data_d = {data_q[2*WIDTH-1:WIDTH], res_d};
      end
      OP_MUL: begin
        acc_d  = acc_q + mul_add;
        data_d = data_q << 1;
        b_d    = b_q >> 1;
        res_d  = acc_d[WIDTH-1:0];
        v_d    = |acc_d[2*WIDTH-1:WIDTH];
      end
      default: res_d = '0;
    endcase
    flags_d = {v_d, res_d[WIDTH-1], ~|res_d};
  end

  // Control FSM with registered handshake outputs. Single-cycle ops and
  // zero-amount shifts spend exactly one evaluation cycle in BUSY (count=1),
  // which gives the one-cycle accept-to-valid latency from latched operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      data_q      <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= op_t'(ALUop);
            data_q     <= {{WIDTH{1'b0}}, Ain};
            b_q        <= Bin;
            acc_q      <= '0;
            cnt_q      <= cnt_load;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          data_q <= data_d;
          b_q    <= b_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            out_q       <= res_d;
            z_q         <= flags_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=16) with a result scoreboard.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [2:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_w;
  logic [2:0]  Z;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] r;
    logic [2:0]  z;
    int          lat;
    int          k;
  } exp_t;

  exp_t sb[$];

  alu_multicycle #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_valid(out_valid),
    .out_ready(out_ready), .out(out_w), .Z(Z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: full-width arithmetic, independent of the iterative datapath.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    logic [15:0] r;
    logic        v;
    logic [31:0] p;
    v = 1'b0;
    case (op)
      3'b000: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'b001: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'b010: r = a & b;
      3'b011: r = ~b;
      3'b100: r = a << b[3:0];
      3'b101: r = a >> b[3:0];
      3'b110: r = $unsigned($signed(a) >>> b[3:0]);
      default: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; v = |p[31:16]; end
    endcase
    return {r, v, r[15], (r == 16'h0)};
  endfunction

  function automatic int lat_of(input logic [15:0] b, input logic [2:0] op);
    if (op == 3'b111) return 16;
    if (op[2] && b[3:0] != 4'h0) return int'(b[3:0]);
    return 1;
  endfunction

  // Called just after a rising edge: drive operands, wait for the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [15:0] r, input logic [2:0] z, input int lat);
    exp_t e;
    int   guard = 0;
    e.r = r; e.z = z; e.lat = lat; e.k = 0;
    sb.push_back(e);
    Ain = a; Bin = b; ALUop = op; in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) chk("accept_timeout", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    sb[$].k = cyc;
    in_valid = 1'b0;
    Ain = 16'($urandom); Bin = 16'($urandom); ALUop = 3'($urandom);
  endtask

  task automatic issue_m(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [18:0] m;
    m = model(a, b, op);
    issue(a, b, op, m[18:3], m[2:0], lat_of(b, op));
  endtask

  // Wait for out_valid, then compare against the oldest scoreboard entry.
  task automatic collect(input string tag);
    exp_t e;
    int   n_lo  = 0;
    int   guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      if (in_ready === 1'b0) n_lo++;
      @(posedge clk); #1; guard++;
    end
    chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, ".out"}, {16'h0, out_w}, {16'h0, e.r});
    chk({tag, ".Z"}, {29'h0, Z}, {29'h0, e.z});
    chk({tag, ".latency"}, cyc - e.k, e.lat);
    chk({tag, ".busy_cycles"}, n_lo, e.lat);
    chk({tag, ".in_ready_done"}, {31'h0, in_ready}, 32'h0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".rel_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, ".rel_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  task automatic run_x(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [15:0] r, input logic [2:0] z,
                       input int lat);
    issue(a, b, op, r, z, lat);
    collect(tag);
    release_result(tag);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Ain = '0; Bin = '0; ALUop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", {16'h0, out_w}, 32'h0);
    chk("reset.Z", {29'h0, Z}, 32'h0);
    chk("reset.out_valid", {31'h0, out_valid}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset.in_ready", {31'h0, in_ready}, 32'h1);

    run_x("add_ovf",  16'h7FFF, 16'h0001, 3'b000, 16'h8000, 3'b110, 1);
    run_x("sub_eq",   16'h1234, 16'h1234, 3'b001, 16'h0000, 3'b001, 1);
    run_x("sub_ovf",  16'h8000, 16'h0001, 3'b001, 16'h7FFF, 3'b100, 1);
    run_x("mul_ovf",  16'h0100, 16'h0100, 3'b111, 16'h0000, 3'b101, 16);
    run_x("mul_3x5",  16'h0003, 16'h0005, 3'b111, 16'h000F, 3'b000, 16);
    run_x("asr4",     16'h8000, 16'h0004, 3'b110, 16'hF800, 3'b010, 4);
    run_x("lsr4",     16'h8000, 16'h0004, 3'b101, 16'h0800, 3'b000, 4);
    run_x("lsl0",     16'h1234, 16'h0010, 3'b100, 16'h1234, 3'b000, 1);
    run_x("lsl15",    16'h0003, 16'h000F, 3'b100, 16'h8000, 3'b010, 15);
    run_x("not",      16'h5555, 16'h00FF, 3'b011, 16'hFF00, 3'b010, 1);
    run_x("and",      16'hF0F0, 16'h0F0F, 3'b010, 16'h0000, 3'b001, 1);

    for (int i = 0; i < 8; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'(i);
      issue_m(ra, rb, rop);
      collect("rand");
      release_result("rand");
    end

    // Backpressure: result held while new operands wait at the input.
    issue(16'h1111, 16'h2222, 3'b000, 16'h3333, 3'b000, 1);
    collect("bp_first");
    Ain = 16'hF0F0; Bin = 16'h0FF0; ALUop = 3'b010; in_valid = 1'b1;
    begin
      exp_t e;
      e.r = 16'h00F0; e.z = 3'b000; e.lat = 1; e.k = 0;
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.out", {16'h0, out_w}, 32'h3333);
      chk("bp.Z", {29'h0, Z}, 32'h0);
      chk("bp.out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp.in_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.handoff_valid", {31'h0, out_valid}, 32'h0);
    chk("bp.handoff_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    sb[$].k = cyc;
    in_valid = 1'b0;
    collect("bp_second");
    release_result("bp_second");

    // Reset in the middle of a multiply discards it.
    issue(16'h0100, 16'h0100, 3'b111, 16'h0000, 3'b101, 16);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid.out", {16'h0, out_w}, 32'h0);
    chk("rst_mid.Z", {29'h0, Z}, 32'h0);
    chk("rst_mid.out_valid", {31'h0, out_valid}, 32'h0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.in_ready", {31'h0, in_ready}, 32'h1);
    run_x("add_after_rst", 16'h0002, 16'h0003, 3'b000, 16'h0005, 3'b000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
